// File: rtl/seven_segment_scan_if.sv
// Signal bundle between a display controller and the seven-segment scan driver:
// value/load/blanking inputs towards the driver, scan outputs back to the consumer.
interface seven_segment_scan_if #(
    parameter int DIGITS = 4
) ();
    localparam int IDXW = $clog2(DIGITS);

    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;

    logic [3:0]            num;
    logic [DIGITS-1:0]     an;
    logic                  dp;
    logic [IDXW-1:0]       idx;
    logic                  frame;

    modport master (
        output load, value, dp_in, blank_lz,
        input  num, an, dp, idx, frame
    );

    modport slave (
        input  load, value, dp_in, blank_lz,
        output num, an, dp, idx, frame
    );
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed scan driver for a common-anode seven-segment display with
// frame-synchronous double-buffered value updates and optional leading-zero blanking.
module seven_segment_scan #(
    parameter int  DIGITS      = 4,
    parameter int  REFRESH_DIV = 50000,
    localparam int IDXW        = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    seven_segment_scan_if.slave bus
);
    localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int VALW = 4 * DIGITS;

    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [VALW-1:0]   sh_val_q, sh_val_d;
    logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [VALW-1:0]   d_val_q, d_val_d;
    logic [DIGITS-1:0] d_dp_q, d_dp_d;
    logic              pending_q, pending_d;
    logic              wrap_q, wrap_d;

    logic [3:0]        num_q, num_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;
    logic [IDXW-1:0]   idx_out_q, idx_out_d;
    logic              frame_q, frame_d;

    logic              tick_s;
    logic              last_digit_s;
    logic              wrap_s;
    logic [DIGITS-1:0] upper_zero_s;
    logic [DIGITS-1:0] an_sel_s;
    logic [3:0]        nib_s;
    logic              dp_bit_s;
    logic              sel_zero_s;
    logic              blank_s;

    // Dwell prescaler, digit index and frame-wrap detection.
    always_comb begin
        tick_s       = (cnt_q == CNTW'(REFRESH_DIV - 1));
        last_digit_s = (idx_q == IDXW'(DIGITS - 1));
        wrap_s       = tick_s && last_digit_s;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        if (tick_s) begin
            cnt_d = '0;
            if (last_digit_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow/display buffering; a load coinciding with the wrap bypasses the shadow.
    always_comb begin
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        d_val_d   = d_val_q;
        d_dp_d    = d_dp_q;
        pending_d = pending_q;
        if (bus.load) begin
            sh_val_d = bus.value;
            sh_dp_d  = bus.dp_in;
        end else begin
            sh_val_d = sh_val_q;
            sh_dp_d  = sh_dp_q;
        end
        if (wrap_s && bus.load) begin
            d_val_d   = bus.value;
            d_dp_d    = bus.dp_in;
            pending_d = 1'b0;
        end else if (wrap_s && pending_q) begin
            d_val_d   = sh_val_q;
            d_dp_d    = sh_dp_q;
            pending_d = 1'b0;
        end else if (bus.load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Current-digit selection and leading-zero detection over the displayed value.
    always_comb begin
        upper_zero_s           = '0;
        an_sel_s               = '1;
        nib_s                  = 4'h0;
        dp_bit_s               = 1'b0;
        sel_zero_s             = 1'b0;
        upper_zero_s[DIGITS-1] = (d_val_q[VALW-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero_s[i] = upper_zero_s[i+1] && (d_val_q[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_s       = d_val_q[4*i +: 4];
                dp_bit_s    = d_dp_q[i];
                an_sel_s[i] = 1'b0;
                sel_zero_s  = upper_zero_s[i];
            end else begin
                an_sel_s[i] = 1'b1;
            end
        end
        if (bus.blank_lz && (idx_q != '0) && sel_zero_s) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end

    // Next output values; frame trails the wrap by two edges so it lines up with digit 0 on an.
    always_comb begin
        num_d     = nib_s;
        idx_out_d = idx_q;
        wrap_d    = wrap_s;
        frame_d   = wrap_q;
        if (blank_s) begin
            an_d = '1;
            dp_d = 1'b1;
        end else begin
            an_d = an_sel_s;
            dp_d = ~dp_bit_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            d_val_q   <= '0;
            d_dp_q    <= '0;
            pending_q <= 1'b0;
            wrap_q    <= 1'b0;
            num_q     <= 4'h0;
            an_q      <= '1;
            dp_q      <= 1'b1;
            idx_out_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            d_val_q   <= d_val_d;
            d_dp_q    <= d_dp_d;
            pending_q <= pending_d;
            wrap_q    <= wrap_d;
            num_q     <= num_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            idx_out_q <= idx_out_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.num   = num_q;
    assign bus.an    = an_q;
    assign bus.dp    = dp_q;
    assign bus.idx   = idx_out_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan: directed scenarios plus random loads,
// compared every cycle against a load-history model of the display.
module tb_seven_segment_scan;
    localparam int D  = 4;
    localparam int R  = 4;
    localparam int DR = D * R;

    logic clk;
    logic rst;

    seven_segment_scan_if #(.DIGITS(D)) sif ();

    seven_segment_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int k_edges = 0;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  d;
    } load_t;
    load_t hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (k=%0d, t=%0t)", name, act, exp, k_edges, $time);
        end
    endtask

    // Reference: output after clean edge k reflects state after k-1 edges; the displayed
    // value is the last load sampled at or before the most recent frame boundary edge.
    initial begin : model
        logic        r, l, b;
        logic [15:0] v, shown;
        logic [3:0]  d, shown_dp, e_num, e_an;
        logic        e_dp, e_frame, blanked;
        int          s, idx, w, e_idx;
        forever begin
            @(posedge clk);
            r = rst; l = sif.load; v = sif.value; d = sif.dp_in; b = sif.blank_lz;
            if (r) begin
                k_edges = 0;
                hist.delete();
                e_num = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_idx = 0; e_frame = 1'b0;
            end else begin
                k_edges++;
                if (l) hist.push_back('{k_edges, v, d});
                s   = k_edges - 1;
                idx = (s / R) % D;
                w   = (s / DR) * DR;
                shown = 16'h0; shown_dp = 4'h0;
                foreach (hist[j]) begin
                    if (hist[j].at <= w) begin
                        shown    = hist[j].v;
                        shown_dp = hist[j].d;
                    end
                end
                blanked = b && (idx != 0) && ((shown >> (4 * idx)) == 16'h0);
                e_num   = 4'((shown >> (4 * idx)) & 16'hF);
                e_an    = blanked ? 4'hF : 4'(~(1 << idx));
                e_dp    = blanked ? 1'b1 : ~shown_dp[idx];
                e_idx   = idx;
                e_frame = (s > 0) && (s % DR == 0);
            end
            @(negedge clk);
            check("model_num",   sif.num,   e_num);
            check("model_an",    sif.an,    e_an);
            check("model_dp",    sif.dp,    e_dp);
            check("model_idx",   sif.idx,   e_idx);
            check("model_frame", sif.frame, e_frame);
        end
    end

    task automatic wait_k(input int t);
        int budget;
        budget = 0;
        while (k_edges < t) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                checks++;
                errors++;
                $display("FAIL wait_k: reached k=%0d required %0d", k_edges, t);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        sif.load  = 1'b1;
        sif.value = v;
        sif.dp_in = d;
        @(negedge clk);
        sif.load  = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] rv;
        rst = 1'b1; sif.load = 1'b0; sif.value = 16'h0; sif.dp_in = 4'h0; sif.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", sif.an, 4'hF);
        check("rst_dp", sif.dp, 1'b1);
        check("rst_num", sif.num, 4'h0);
        rst = 1'b0;
        check("rel_an_still_off", sif.an, 4'hF);
        wait_k(1);  check("first_an", sif.an, 4'b1110); check("first_num", sif.num, 4'h0);

        // Deferred load at cycle 5
        wait_k(4);  do_load(16'h1234, 4'h0);
        wait_k(16); check("defer_hold_num", sif.num, 4'h0); check("defer_an3", sif.an, 4'b0111);
        wait_k(17); check("defer_num0", sif.num, 4'h4); check("defer_frame", sif.frame, 1'b1);
                    check("defer_an0", sif.an, 4'b1110);
        wait_k(18); check("frame_one_cycle", sif.frame, 1'b0);
        wait_k(29); check("defer_num3", sif.num, 4'h1);

        // Leading-zero blanking
        wait_k(33); sif.blank_lz = 1'b1; do_load(16'h0050, 4'h0);
        wait_k(49); check("blank_d0_num", sif.num, 4'h0); check("blank_d0_an", sif.an, 4'b1110);
        wait_k(53); check("blank_d1_num", sif.num, 4'h5); check("blank_d1_an", sif.an, 4'b1101);
        wait_k(57); check("blank_d2_an", sif.an, 4'hF); check("blank_d2_dp", sif.dp, 1'b1);
        wait_k(60); do_load(16'h0000, 4'h0);
        wait_k(65); check("zero_d0_an", sif.an, 4'b1110);
        wait_k(69); check("zero_d1_an", sif.an, 4'hF);

        // Last load in a frame wins, decimal point on digit 2
        wait_k(72); sif.blank_lz = 1'b0; do_load(16'hAAAA, 4'hF);
        wait_k(75); do_load(16'hBEEF, 4'b0100);
        wait_k(81); check("lw_num0", sif.num, 4'hF); check("lw_dp0", sif.dp, 1'b1);
        wait_k(89); check("lw_num2", sif.num, 4'hE); check("lw_dp2", sif.dp, 1'b0);
        wait_k(93); check("lw_num3", sif.num, 4'hB); check("lw_dp3", sif.dp, 1'b1);

        // Load exactly in the wrap cycle
        wait_k(95); do_load(16'h9876, 4'h0);
        wait_k(97);  check("byp_num0", sif.num, 4'h6); check("byp_frame", sif.frame, 1'b1);
        wait_k(109); check("byp_num3", sif.num, 4'h9);
        wait_k(113); check("byp_still", sif.num, 4'h6);

        // Mid-frame reset with a load still pending
        wait_k(117); do_load(16'h5555, 4'hF);
        wait_k(122); check("mid_idx", sif.idx, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_an", sif.an, 4'hF); check("mrst_num", sif.num, 4'h0);
        check("mrst_idx", sif.idx, 2'd0); check("mrst_frame", sif.frame, 1'b0);
        rst = 1'b0;
        wait_k(1);  check("mrst_restart_an", sif.an, 4'b1110);
        wait_k(17); check("mrst_discard", sif.num, 4'h0); check("mrst_frame2", sif.frame, 1'b1);

        // Random loads, blanking changes and dwell phases
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) sif.blank_lz = 1'($urandom_range(0, 1));
            rv = 16'($urandom);
            rv = rv >> (4 * $urandom_range(0, 4));
            do_load(rv, 4'($urandom));
        end
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
